stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It generates the write-enable and flush controls for the PC and the F/D, D/E, E/M and M/W pipeline registers. It detects register read-after-write hazards from per-stage Tuse/Tnew information. It owns the multi-cycle multiply/divide busy counter that blocks HI/LO-class instructions in D, and it keeps a free-running stall-cycle counter for performance debug.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles after a mult/multu start; legal range 1..15.
- DIV_CYCLES, default 10: busy cycles after a div/divu start; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- D_rs_addr  input  5  rs field of the instruction in D.
- D_rt_addr  input  5  rt field of the instruction in D.
- D_rs_tuse  input  2  cycles until D needs rs; 3 = rs not read.
- D_rt_tuse  input  2  cycles until D needs rt; 3 = rt not read.
- D_is_md  input  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_wa  input  5  destination register of the instruction in E; 0 = none.
- E_tnew  input  2  cycles until E's result can be forwarded.
- M_wa  input  5  destination register of the instruction in M; 0 = none.
- M_tnew  input  2  cycles until M's result can be forwarded.
- E_md_start  input  1  E holds mult/multu/div/divu this cycle.
- E_md_div  input  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
- PC_WE  output  1  PC write enable.
- D_WE  output  1  F/D register write enable.
- E_flush  output  1  D/E register loads a bubble (all-zero instruction).
- M_WE  output  1  E/M register write enable.
- W_WE  output  1  M/W register write enable.
- stall  output  1  a stall is being taken this cycle.
- md_busy  output  1  the multiply/divide unit is computing.
- md_done  output  1  one-cycle pulse in the last busy cycle.
- stall_cnt  output  32  total number of stall cycles since reset.

## Operation
- rs hazard: hz_rs = D_rs_addr != 0 and one of the following holds:
  - D_rs_addr == E_wa and D_rs_tuse < E_tnew, or
  - D_rs_addr == M_wa and D_rs_tuse < M_tnew.
- rt hazard: hz_rt is the same rule applied to rt. A tuse value of 3 never produces a hazard.
- MD hazard: hz_md = D_is_md and (md_busy or E_md_start). E_md_start enters the equation combinationally, so a HI/LO-class instruction directly behind a mult/div also stalls.
- stall = hz_rs or hz_rt or hz_md.
- PC_WE = D_WE = not stall. E_flush = stall. M_WE = W_WE = 1, because E, M and W always advance.
- MD counter (4-bit, cnt):
  - When E_md_start = 1 and cnt == 0, load cnt with DIV_CYCLES if E_md_div = 1, otherwise MULT_CYCLES.
  - Otherwise, if cnt != 0, decrement cnt by 1.
  - E_md_start while cnt != 0 cannot occur under correct stalling. If it does occur, the start is ignored and cnt keeps decrementing.
- md_busy = (cnt != 0), decoded from the register output. md_done = (cnt == 1).
- stall_cnt increments by 1 on every clock edge where stall = 1 and rst = 0. It wraps from 0xFFFFFFFF to 0.
- All outputs except cnt and stall_cnt are combinational from the inputs and cnt. There are no other state elements.

## Timing
- Reset: cnt = 0 and stall_cnt = 0 on the first edge with rst = 1. While rst = 1, the outputs follow the equations with cnt = 0.
  - Expected values with idle inputs (all zeros, tuse = 3): PC_WE = D_WE = M_WE = W_WE = 1, E_flush = 0, stall = 0, md_busy = 0, md_done = 0.
- Reset mid-operation: an asserted rst aborts a multiply/divide in progress. md_busy is 0 in the cycle after the reset edge.
- Hazard stalls have zero latency: stall is asserted in the same cycle the hazard condition appears, and deasserts in the same cycle it clears.
- MD latency: with E_md_start in cycle 0, md_busy = 1 in cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
  - md_done = 1 in cycle N.
  - md_busy = 0 in cycle N+1, and a waiting mfhi/mflo is released in that cycle.
  - A new E_md_start in cycle N+1 reloads cnt, so the unit can run back-to-back.
- Simultaneous events:
  - A register hazard and an MD hazard together produce a single stall; stall_cnt increments by 1.
  - A stall during an MD countdown does not pause the counter.
- Write-enable polarity: stall must never deassert M_WE or W_WE.

## Test plan
- Load-use stall: E_wa=5, E_tnew=2, D_rs_addr=5, D_rs_tuse=1 -> stall=1, PC_WE=0, D_WE=0, E_flush=1, M_WE=W_WE=1. Next cycle with E_tnew=1 -> stall=0.
- Register $0 and unused operands: E_wa=0 with D_rs_addr=0, then D_rt_tuse=3 matching M_wa=7 with M_tnew=2 -> stall=0 in both cases; stall_cnt unchanged.
- Mult sequencing: E_md_start=1, E_md_div=0 in cycle 0, with D_is_md=1 held throughout -> stall=1 in cycles 0..5, md_done=1 in cycle 5, stall=0 in cycle 6, stall_cnt=6.
- Div back-to-back: a div start in cycle 0 gives md_busy=1 for cycles 1..10. A second start in cycle 11 gives md_busy=1 for cycles 12..21.
- Reset mid-divide: assert rst in cycle 4 of a div -> md_busy=0 and stall_cnt=0 in cycle 5; PC_WE=1 with D_is_md=1 once rst is released.
- Counter wrap: force stall_cnt to 0xFFFFFFFF (via a hierarchical deposit) and apply one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// Hazard-information and pipeline-control bundle shared by the
// decode/execute datapath and the stall controller.
interface stall_ctrl_if;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;

    logic        PC_WE;
    logic        D_WE;
    logic        E_flush;
    logic        M_WE;
    logic        W_WE;
    logic        stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;

    modport master (
        output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
        output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  PC_WE, D_WE, E_flush, M_WE, W_WE,
        input  stall, md_busy, md_done, stall_cnt
    );

    modport slave (
        input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
        input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output PC_WE, D_WE, E_flush, M_WE, W_WE,
        output stall, md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Hazard detection, stall/flush generation, mult/div busy counter and
// stall-cycle performance counter for the five-stage core.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         rst,
    stall_ctrl_if.slave bus
);
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    logic rs_e;
    logic rs_m;
    logic rt_e;
    logic rt_m;
    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic busy;
    logic stall;

    // tuse of 3 can never be below a 2-bit tnew, so unused operands drop out
    assign rs_e = (bus.D_rs_addr == bus.E_wa) && (bus.D_rs_tuse < bus.E_tnew);
    assign rs_m = (bus.D_rs_addr == bus.M_wa) && (bus.D_rs_tuse < bus.M_tnew);
    assign rt_e = (bus.D_rt_addr == bus.E_wa) && (bus.D_rt_tuse < bus.E_tnew);
    assign rt_m = (bus.D_rt_addr == bus.M_wa) && (bus.D_rt_tuse < bus.M_tnew);

    assign hz_rs = (bus.D_rs_addr != 5'd0) && (rs_e || rs_m);
    assign hz_rt = (bus.D_rt_addr != 5'd0) && (rt_e || rt_m);

    assign busy  = (cnt_q != 4'd0);
    assign hz_md = bus.D_is_md && (busy || bus.E_md_start);
    assign stall = hz_rs || hz_rt || hz_md;

    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = 4'd0;
        end else if (bus.E_md_start && !busy) begin
            cnt_d = bus.E_md_div ? DIV_LD : MULT_LD;
        end else if (busy) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            stall_cnt_d = 32'd0;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q       <= cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall     = stall;
    assign bus.PC_WE     = !stall;
    assign bus.D_WE      = !stall;
    assign bus.E_flush   = stall;
    assign bus.M_WE      = 1'b1;
    assign bus.W_WE      = 1'b1;
    assign bus.md_busy   = busy;
    assign bus.md_done   = (cnt_q == 4'd1);
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Directed vector table plus multi-cycle sequences for stall_ctrl.
module tb_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stall_ctrl_if bus ();

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] rs_tu;
        logic [1:0] rt_tu;
        logic       md;
        logic [4:0] ewa;
        logic [1:0] etn;
        logic [4:0] mwa;
        logic [1:0] mtn;
        logic       stall;
    } vec_t;

    vec_t vt[12];

    function automatic vec_t mk(
        logic [4:0] rs, logic [1:0] rs_tu,
        logic [4:0] rt, logic [1:0] rt_tu, logic md,
        logic [4:0] ewa, logic [1:0] etn,
        logic [4:0] mwa, logic [1:0] mtn, logic st);
        vec_t v;
        v.rs = rs; v.rs_tu = rs_tu; v.rt = rt; v.rt_tu = rt_tu;
        v.md = md; v.ewa = ewa; v.etn = etn; v.mwa = mwa; v.mtn = mtn;
        v.stall = st;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.D_rs_addr  = 5'd0;
        bus.D_rt_addr  = 5'd0;
        bus.D_rs_tuse  = 2'd3;
        bus.D_rt_tuse  = 2'd3;
        bus.D_is_md    = 1'b0;
        bus.E_wa       = 5'd0;
        bus.E_tnew     = 2'd0;
        bus.M_wa       = 5'd0;
        bus.M_tnew     = 2'd0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
    endtask

    task automatic apply(vec_t v);
        bus.D_rs_addr = v.rs;
        bus.D_rt_addr = v.rt;
        bus.D_rs_tuse = v.rs_tu;
        bus.D_rt_tuse = v.rt_tu;
        bus.D_is_md   = v.md;
        bus.E_wa      = v.ewa;
        bus.E_tnew    = v.etn;
        bus.M_wa      = v.mwa;
        bus.M_tnew    = v.mtn;
    endtask

    task automatic ctl(string name, logic st);
        check({name, ".stall"},   32'(bus.stall),   32'(st));
        check({name, ".PC_WE"},   32'(bus.PC_WE),   32'(!st));
        check({name, ".D_WE"},    32'(bus.D_WE),    32'(!st));
        check({name, ".E_flush"}, 32'(bus.E_flush), 32'(st));
        check({name, ".M_WE"},    32'(bus.M_WE),    32'd1);
        check({name, ".W_WE"},    32'(bus.W_WE),    32'd1);
    endtask

    // advance to just after the next rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int c;
        logic eb;

        //            rs tu rt tu md ewa etn mwa mtn stall
        vt[0]  = mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(5, 1, 0, 3, 0, 5, 2, 0, 0, 1);
        vt[2]  = mk(5, 1, 0, 3, 0, 5, 1, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 3, 0, 0, 2, 0, 0, 0);
        vt[4]  = mk(0, 3, 7, 3, 0, 0, 0, 7, 2, 0);
        vt[5]  = mk(0, 3, 7, 1, 0, 0, 0, 7, 2, 1);
        vt[6]  = mk(0, 3, 7, 2, 0, 0, 0, 7, 2, 0);
        vt[7]  = mk(9, 0, 0, 3, 0, 0, 0, 9, 1, 1);
        vt[8]  = mk(9, 0, 0, 3, 0, 9, 0, 9, 1, 1);
        vt[9]  = mk(4, 0, 0, 3, 0, 5, 3, 0, 0, 0);
        vt[10] = mk(0, 3, 0, 3, 1, 0, 0, 0, 0, 0);
        vt[11] = mk(3, 0, 3, 0, 0, 3, 3, 0, 0, 1);

        idle();
        rst = 1'b1;
        next();
        next();
        @(negedge clk);
        ctl("reset", 1'b0);
        check("reset.md_busy",   32'(bus.md_busy),   32'd0);
        check("reset.md_done",   32'(bus.md_done),   32'd0);
        check("reset.stall_cnt", bus.stall_cnt,      32'd0);

        // stall seen while rst is high must not count
        apply(vt[1]);
        next();
        check("rst_stall.cnt", bus.stall_cnt, 32'd0);
        rst = 1'b0;

        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            apply(vt[i]);
            @(negedge clk);
            ctl($sformatf("vec%0d", i), vt[i].stall);
            check($sformatf("vec%0d.cnt", i), bus.stall_cnt, 32'(exp_cnt));
            check($sformatf("vec%0d.busy", i), 32'(bus.md_busy), 32'd0);
            if (vt[i].stall) exp_cnt++;
            next();
        end
        check("vec_end.cnt", bus.stall_cnt, 32'(exp_cnt));

        // mult with a HI/LO reader held in D
        do_reset();
        bus.D_is_md    = 1'b1;
        bus.E_md_start = 1'b1;
        for (c = 0; c <= 6; c++) begin
            @(negedge clk);
            ctl($sformatf("mult_c%0d", c), c <= 5);
            check($sformatf("mult_c%0d.busy", c), 32'(bus.md_busy),
                  32'(c >= 1 && c <= 5));
            check($sformatf("mult_c%0d.done", c), 32'(bus.md_done),
                  32'(c == 5));
            next();
            bus.E_md_start = 1'b0;
        end
        @(negedge clk);
        check("mult.stall_cnt", bus.stall_cnt, 32'd6);
        next();

        // back-to-back divides
        do_reset();
        bus.E_md_start = 1'b1;
        bus.E_md_div   = 1'b1;
        for (c = 0; c <= 22; c++) begin
            bus.E_md_start = (c == 0 || c == 11);
            @(negedge clk);
            eb = (c >= 1 && c <= 10) || (c >= 12 && c <= 21);
            check($sformatf("div_c%0d.busy", c), 32'(bus.md_busy), 32'(eb));
            check($sformatf("div_c%0d.done", c), 32'(bus.md_done),
                  32'(c == 10 || c == 21));
            next();
        end
        bus.E_md_start = 1'b0;
        check("div.stall_cnt", bus.stall_cnt, 32'd0);

        // reset aborts a divide in progress
        do_reset();
        bus.E_md_start = 1'b1;
        bus.E_md_div   = 1'b1;
        next();
        bus.E_md_start = 1'b0;
        bus.D_is_md    = 1'b1;
        next();
        next();
        next();
        rst = 1'b1;
        @(negedge clk);
        check("rstdiv_c4.busy", 32'(bus.md_busy), 32'd1);
        ctl("rstdiv_c4", 1'b1);
        check("rstdiv_c4.cnt", bus.stall_cnt, 32'd3);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("rstdiv_c5.busy", 32'(bus.md_busy), 32'd0);
        check("rstdiv_c5.cnt", bus.stall_cnt, 32'd0);
        ctl("rstdiv_c5", 1'b0);
        next();
        bus.D_is_md = 1'b0;

        // register and MD hazard together count once; counter wraps
        bus.D_is_md   = 1'b1;
        bus.E_md_start = 1'b1;
        bus.D_rs_addr = 5'd5;
        bus.D_rs_tuse = 2'd0;
        bus.E_wa      = 5'd5;
        bus.E_tnew    = 2'd2;
        @(negedge clk);
        check("both.stall", 32'(bus.stall), 32'd1);
        next();
        check("both.cnt", bus.stall_cnt, 32'd1);
        idle();
        bus.D_rs_addr = 5'd5;
        bus.D_rs_tuse = 2'd0;
        bus.E_wa      = 5'd5;
        bus.E_tnew    = 2'd2;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        @(negedge clk);
        check("wrap.pre", bus.stall_cnt, 32'hFFFF_FFFF);
        next();
        check("wrap.post", bus.stall_cnt, 32'd0);
        idle();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
